sram_bist_engine: RTL and testbench

- Self-test request generator that sits directly upstream of the single-port SRAM controller.
- Drives the controller's mem/rw/addr/data_f2s request interface and consumes its ready and registered read-data output (data_s2f_r).
- On start, writes a selectable pattern over an address range, then reads the range back and compares each word.
- Reports pass/fail, an error count and the first failing location.

---
 rtl/sram_bist_engine.sv | 196 +++++++++++++++++++
 tb/tb_sram_bist_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_engine.sv
// sram_bist_engine: self-test request generator placed in front of the single-port SRAM
// controller. On an accepted start it writes a selectable pattern over an address range, then
// reads the range back and compares every word.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   start                   one-cycle pulse, accepted only in IDLE or DONE
//   start_addr, end_addr    inclusive address range, latched on accepted start
//   pat_sel, seed           pattern select and pattern-3 constant, latched on accepted start
//   mem, rw, addr, data_f2s request interface to the controller (rw: 1=read, 0=write)
//   ready                   controller idle; a request is taken in any cycle with mem && ready
//   data_s2f_r              controller registered read data, valid two cycles after a read
//   busy, done, pass        status; pass is meaningful only while done
//   err_count               saturating mismatch count
//   first_err_addr/data     location and read value of the first mismatch
module sram_bist_engine #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [1:0]        pat_sel,
    input  logic [DATA_W-1:0] seed,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    // Checkerboard words: 1010... for even addresses, 0101... for odd ones.
    localparam logic [DATA_W-1:0] PatEven = DATA_W'({((DATA_W + 1) / 2){2'b10}});
    localparam logic [DATA_W-1:0] PatOdd  = ~PatEven;

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] start_q, end_q;
    logic [1:0]        pat_q;
    logic [DATA_W-1:0] seed_q;

    // Two-stage compare pipeline matching the controller's read latency.
    logic              s1_v_q, s2_v_q;
    logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
    logic [DATA_W-1:0] s1_exp_q, s2_exp_q;

    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] ferr_addr_q;
    logic [DATA_W-1:0] ferr_data_q;

    logic              start_ok;
    logic              last;
    logic              push;
    logic              mismatch;
    logic [DATA_W-1:0] exp_ptr;

    assign start_ok = start && (state_q == StIdle || state_q == StDone);
    assign last     = (ptr_q == end_q);
    assign mismatch = s2_v_q && (data_s2f_r != s2_exp_q);

    // Expected word for the current pointer.
    always_comb begin
        unique case (pat_q)
            2'd0:    exp_ptr = DATA_W'(ptr_q);
            2'd1:    exp_ptr = ~(DATA_W'(ptr_q));
            2'd2:    exp_ptr = ptr_q[0] ? PatOdd : PatEven;
            default: exp_ptr = seed_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        push     = 1'b0;
        mem      = 1'b0;
        rw       = 1'b1;
        addr     = '0;
        data_f2s = '0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    ptr_d   = start_addr;
                    state_d = (start_addr > end_addr) ? StDone : StWrite;
                end
            end
            StWrite: begin
                mem      = 1'b1;
                rw       = 1'b0;
                addr     = ptr_q;
                data_f2s = exp_ptr;
                if (ready) begin
                    if (last) begin
                        ptr_d   = start_q;
                        state_d = StRead;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            StRead: begin
                mem  = 1'b1;
                addr = ptr_q;
                if (ready) begin
                    push = 1'b1;
                    if (last) begin
                        state_d = StDrain;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            StDrain: begin
                // Stage 2 is compared this cycle; once stage 1 is empty nothing is left after it.
                if (!s1_v_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            start_q   <= '0;
            end_q     <= '0;
            pat_q     <= '0;
            seed_q    <= '0;
            s1_v_q    <= 1'b0;
            s1_addr_q <= '0;
            s1_exp_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_addr_q <= '0;
            s2_exp_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (start_ok) begin
                start_q <= start_addr;
                end_q   <= end_addr;
                pat_q   <= pat_sel;
                seed_q  <= seed;
            end
            s1_v_q <= push;
            if (push) begin
                s1_addr_q <= ptr_q;
                s1_exp_q  <= exp_ptr;
            end
            s2_v_q    <= s1_v_q;
            s2_addr_q <= s1_addr_q;
            s2_exp_q  <= s1_exp_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
        end else if (start_ok) begin
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
        end else if (mismatch) begin
            // The counter saturates and never returns to zero, so zero means no mismatch yet.
            if (err_q == '0) begin
                ferr_addr_q <= s2_addr_q;
                ferr_data_q <= data_s2f_r;
            end
            if (err_q != '1) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

    assign busy           = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = (state_q == StDone) && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_sram_bist_engine.sv
// Bench for sram_bist_engine: a behavioural SRAM controller model with fault injection, a
// scoreboard fed by the stimulus process and a monitor that checks every accepted request and
// every completed test.
module tb_sram_bist_engine;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int ERR_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [1:0]        pat_sel = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              mem, rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;
    logic              busy, done, pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;

    sram_bist_engine #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .pat_sel       (pat_sel),
        .seed          (seed),
        .mem           (mem),
        .rw            (rw),
        .addr          (addr),
        .data_f2s      (data_f2s),
        .ready         (ready),
        .data_s2f_r    (data_s2f_r),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fault / timing controls for the controller model.
    logic              stall_en = 1'b0;
    logic              zero_reads = 1'b0;
    logic              flip_en = 1'b0;
    logic [ADDR_W-1:0] flip_addr = '0;
    logic [DATA_W-1:0] flip_mask = '0;

    logic [DATA_W-1:0] sram [0:(1 << ADDR_W) - 1];
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_pend_addr;

    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = sram[a];
        if (flip_en && a == flip_addr) v = v ^ flip_mask;
        if (zero_reads) v = '0;
        return v;
    endfunction

    // Controller model: busy for one cycle after each acceptance, read data registered and
    // visible two cycles after the read is accepted; optional random extra stalls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ready        <= 1'b1;
            data_s2f_r   <= '0;
            rd_pend      <= 1'b0;
            rd_pend_addr <= '0;
        end else begin
            rd_pend <= 1'b0;
            if (rd_pend) data_s2f_r <= read_val(rd_pend_addr);
            if (mem && ready) begin
                ready <= 1'b0;
                if (rw) begin
                    rd_pend      <= 1'b1;
                    rd_pend_addr <= addr;
                end else begin
                    sram[addr] <= data_f2s;
                end
            end else begin
                ready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Scoreboard.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    typedef struct {
        logic              pass;
        logic [ERR_W-1:0]  err;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fd;
        int                lat;
        int unsigned       c0;
    } res_t;

    wr_t               wr_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    res_t              res_q[$];
    int                starts_issued = 0;
    int                results_seen = 0;
    int                checks = 0;
    int                errors = 0;

    function automatic logic [DATA_W-1:0] pat_of(input logic [1:0] p, input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] sd);
        case (p)
            2'd0:    return a[DATA_W-1:0];
            2'd1:    return ~a[DATA_W-1:0];
            2'd2:    return a[0] ? 16'h5555 : 16'hAAAA;
            default: return sd;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: the only process that compares.
    initial begin : monitor
        bit rst_seen = 1'b0;
        int wait_cyc = 0;
        res_t r;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!rst_seen) begin
                    chk("reset_outputs",
                        {mem, rw, addr, data_f2s, busy, done, pass, err_count, first_err_addr,
                         first_err_data},
                        {1'b0, 1'b1, 18'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 18'h0, 16'h0});
                end
                rst_seen = 1'b1;
                wr_q.delete();
                rd_q.delete();
                res_q.delete();
                results_seen = starts_issued;
                wait_cyc = 0;
            end else begin
                rst_seen = 1'b0;
                if (mem && ready) begin
                    if (!rw) begin
                        chk("write_expected", wr_q.size() != 0, 1);
                        if (wr_q.size() != 0) begin
                            chk("write_addr", addr, wr_q[0].a);
                            chk("write_data", data_f2s, wr_q[0].d);
                            void'(wr_q.pop_front());
                        end
                    end else begin
                        chk("read_expected", rd_q.size() != 0, 1);
                        if (rd_q.size() != 0) begin
                            chk("read_addr", addr, rd_q.pop_front());
                        end
                    end
                end
                if (starts_issued != results_seen) begin
                    wait_cyc++;
                    if (done && res_q.size() != 0) begin
                        r = res_q.pop_front();
                        chk("pass", pass, r.pass);
                        chk("err_count", err_count, r.err);
                        chk("first_err_addr", first_err_addr, r.fa);
                        chk("first_err_data", first_err_data, r.fd);
                        chk("busy_at_done", busy, 0);
                        chk("requests_left", wr_q.size() + rd_q.size(), 0);
                        if (r.lat >= 0) chk("done_latency", cyc - r.c0, r.lat);
                        results_seen++;
                        wait_cyc = 0;
                    end else if (wait_cyc > 3000) begin
                        chk("done_within_budget", done, 1);
                        wr_q.delete();
                        rd_q.delete();
                        res_q.delete();
                        results_seen = starts_issued;
                        wait_cyc = 0;
                    end
                end
            end
        end
    end

    // Compute the expected outcome from the range rules, then pulse start.
    task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                         input logic [1:0] p, input logic [DATA_W-1:0] sd,
                         input bit ignore_pulse);
        res_t r;
        int n = 0;
        logic [DATA_W-1:0] ex, got;
        r.fa = '0;
        r.fd = '0;
        for (int a = int'(s); a <= int'(e); a++) begin
            ex = pat_of(p, ADDR_W'(a), sd);
            wr_q.push_back('{ADDR_W'(a), ex});
            rd_q.push_back(ADDR_W'(a));
            got = zero_reads ? '0 : ((flip_en && ADDR_W'(a) == flip_addr) ? ex ^ flip_mask : ex);
            if (got != ex) begin
                if (n == 0) begin
                    r.fa = ADDR_W'(a);
                    r.fd = got;
                end
                n++;
            end
        end
        r.err  = (n > 65535) ? 16'hFFFF : ERR_W'(n);
        r.pass = (n == 0);
        r.lat  = stall_en ? -1 : ((s > e) ? 1 : 4 * (int'(e) - int'(s) + 1) + 2);
        @(negedge clk);
        start_addr = s;
        end_addr   = e;
        pat_sel    = p;
        seed       = sd;
        start      = 1'b1;
        r.c0       = cyc;
        res_q.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        starts_issued++;
        // Scramble config so that unlatched use of the inputs shows up.
        start_addr = ADDR_W'($urandom);
        end_addr   = ADDR_W'($urandom);
        pat_sel    = 2'($urandom);
        seed       = DATA_W'($urandom);
        if (ignore_pulse) begin
            repeat (5) @(negedge clk);
            start_addr = 18'h00000;
            end_addr   = 18'h00001;
            start      = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (results_seen != starts_issued && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) begin
            $display("FAIL wait_done: monitor never closed the test");
            $fatal(1, "bench stalled");
        end
    endtask

    task automatic set_faults(input bit st, input bit z, input bit fe,
                              input logic [ADDR_W-1:0] fa, input logic [DATA_W-1:0] fm);
        stall_en   = st;
        zero_reads = z;
        flip_en    = fe;
        flip_addr  = fa;
        flip_mask  = fm;
    endtask

    initial begin : stimulus
        logic [ADDR_W-1:0] s, e;
        int len, ei, k;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Ideal memory, incrementing pattern.
        set_faults(0, 0, 0, '0, '0);
        issue(18'h00010, 18'h00013, 2'd0, 16'h0, 0);
        wait_done();
        // Checkerboard with one flipped bit.
        set_faults(0, 0, 1, 18'h00012, 16'h0008);
        issue(18'h00010, 18'h00013, 2'd2, 16'h0, 0);
        wait_done();
        // Top of address space, no wrap.
        set_faults(0, 0, 0, '0, '0);
        issue(18'h3FFFE, 18'h3FFFF, 2'd1, 16'h0, 0);
        wait_done();
        // Empty range.
        issue(18'h00005, 18'h00004, 2'd0, 16'h0, 0);
        wait_done();
        // Every read returns zero; second start while busy must be ignored.
        set_faults(0, 1, 0, '0, '0);
        issue(18'h00020, 18'h00023, 2'd3, 16'h1234, 1);
        wait_done();

        // Reset during the read phase, then a clean run.
        set_faults(0, 0, 0, '0, '0);
        issue(18'h00100, 18'h00107, 2'd1, 16'h0, 0);
        k = 0;
        while (!(mem && rw) && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(18'h00100, 18'h00107, 2'd2, 16'h0, 0);
        wait_done();

        // Randomised runs.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 8);
            if ($urandom_range(0, 3) == 0) s = 18'h3FFFF - ADDR_W'($urandom_range(0, 8));
            else s = ADDR_W'($urandom_range(0, 4095));
            if (len == 0 && s == 0) s = 18'h1;
            ei = int'(s) + len - 1;
            if (ei > 'h3FFFF) ei = 'h3FFFF;
            e = ADDR_W'(ei);
            set_faults($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 2) == 0,
                       (len > 0) ? s + ADDR_W'($urandom_range(0, len - 1)) : s,
                       DATA_W'($urandom_range(1, 65535)));
            issue(s, e, 2'($urandom_range(0, 3)), DATA_W'($urandom), 0);
            wait_done();
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
